alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
Multi-cycle issue/write-back controller that drives the datapath ALU.
- Accepts R-type instruction words over a valid/ready handshake and decodes funct to the 4-bit ALU selector.
- Reads operands from an internal 32x32 register file and presents them to the ALU.
- Captures the ALU result and zero flag, then writes the result back.
- Sits between instruction fetch and the combinational ALU; it is the driving end of the OP1/OP2/ALUSel interface and the consuming end of Res/Z.

Parameters:
- NREGS, 32, register file depth (index width 5).
- DW, 32, data width of operands, result and register entries.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction word valid.
- in_ready  out  1  controller can accept an instruction.
- in_instr  in  32  opcode[31:26] rs[25:21] rt[20:16] rd[15:11] funct[5:0].
- alu_op1  out  DW  operand 1 to ALU (registered).
- alu_op2  out  DW  operand 2 to ALU (registered).
- alu_sel  out  4  ALU selector (registered).
- alu_res  in  DW  ALU result.
- alu_z  in  1  ALU zero flag.
- wb_valid  out  1  one-cycle pulse when an instruction retires.
- wb_we  out  1  register file written this retire.
- wb_addr  out  5  destination index.
- wb_data  out  DW  value retired.
- zero_flag  out  1  sticky Z of last non-NOP instruction.
- dbg_we  in  1  debug register write.
- dbg_addr  in  5  debug register index.
- dbg_wdata  in  DW  debug write data.
- dbg_rdata  out  DW  combinational read of rf[dbg_addr].

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all rf entries 0.
  - alu_op1=alu_op2=0; alu_sel=4'b0111.
  - wb_valid=wb_we=0; wb_addr=0; wb_data=0; zero_flag=0.
  - Reset mid-instruction abandons the instruction with no write and no wb_valid.
- FSM IDLE->READ->EXEC->WB->IDLE, one cycle per state. Throughput is one instruction per 4 cycles.
- IDLE:
  - in_ready=1 only in IDLE.
  - Accept on in_valid&&in_ready and latch the instruction; go to READ.
  - Holding in_valid without acceptance changes nothing.
- READ:
  - alu_op1<=rf[rs]; alu_op2<=rf[rt]; alu_sel<=decode(funct).
  - rf[0] always reads 0.
- Decode, only when opcode==0:
  - 0x20 ADD->0000; 0x22 SUB->0001; 0x18 MUL->0010; 0x1A DIV->0011.
  - 0x25 OR->0100; 0x24 AND->0101; 0x2A SLT->0110.
  - Any other funct, or opcode!=0, gives NOP 0111.
- EXEC: capture alu_res and alu_z into internal result registers. NOP does not capture, so the ALU's undriven Res/Z are never sampled.
- WB:
  - wb_valid=1 for exactly one cycle; wb_addr=rd; wb_data=captured result (0 for NOP).
  - wb_we=1 and rf[rd]<=result only if the instruction is not NOP and rd!=0.
  - zero_flag<=captured Z for non-NOP, held for NOP.
  - After WB: alu_sel returns to 0111 and operands hold their values.
- Debug write:
  - Honored only in IDLE; ignored in other states. dbg_addr=0 is ignored.
  - A dbg write in the same cycle as an accept lands first; the instruction's READ sees the new value.
- Arithmetic is done entirely by the ALU. This block applies no width extension; results are truncated to DW.

Optional Feature:
- Macro: ALU_DIV0_GUARD_EN.
- Defined:
  - DIV with rf[rt]==0 is detected in READ; alu_sel is forced to 0111.
  - WB pulses wb_valid with wb_we=0 and wb_data=0; zero_flag is held.
  - Extra output div0_err pulses high for one cycle together with wb_valid.
- Undefined: no check and no div0_err port; whatever the ALU returns is written back.

Test Plan:
- dbg writes r1=5, r2=7; ADD rd=3 -> wb_valid 4 cycles after accept, wb_data=12, rf[3]=12, zero_flag=0.
- r4=9, r5=9; SUB rd=6 -> rf[6]=0, zero_flag=1; then OR r1,r2 rd=7 -> rf[7]=7, zero_flag=0.
- SLT r1(5), r2(7) rd=8 -> rf[8]=1; swapped operands -> rf[8]=0, zero_flag=1.
- ADD rd=0, and opcode=0x08 -> wb_valid=1, wb_we=0, rf[0] reads 0, zero_flag unchanged.
- DIV r1(5)/r9(0) with ALU_DIV0_GUARD_EN -> div0_err=1, wb_we=0, rf[rd] unchanged.
- in_valid held during READ/EXEC/WB -> in_ready=0 and only one accept; rst_n low during EXEC -> no wb_valid, rf cleared, alu_sel=0111.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake and ALU operand/result bus of alu_issue_ctrl.
// master = the controller, slave = fetch + ALU side.
interface alu_issue_ctrl_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic [DW-1:0] alu_op1;
    logic [DW-1:0] alu_op2;
    logic [3:0]    alu_sel;
    logic [DW-1:0] alu_res;
    logic          alu_z;

    modport master (
        input  in_valid, in_instr, alu_res, alu_z,
        output in_ready, alu_op1, alu_op2, alu_sel
    );

    modport slave (
        output in_valid, in_instr, alu_res, alu_z,
        input  in_ready, alu_op1, alu_op2, alu_sel
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Four-cycle issue/write-back controller driving a combinational ALU.
// Optional macro ALU_DIV0_GUARD_EN: suppress DIV by zero, add div0_err.
module alu_issue_ctrl #(
    parameter int NREGS = 32,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_ctrl_if.master bus,
    output logic             wb_valid,
    output logic             wb_we,
    output logic [4:0]       wb_addr,
    output logic [DW-1:0]    wb_data,
    output logic             zero_flag,
    input  logic             dbg_we,
    input  logic [4:0]       dbg_addr,
    input  logic [DW-1:0]    dbg_wdata,
    output logic [DW-1:0]    dbg_rdata
`ifdef ALU_DIV0_GUARD_EN
    ,
    output logic             div0_err
`endif
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] EXEC = 2'd2;
    localparam logic [1:0] WB   = 2'd3;

    localparam logic [3:0] SEL_ADD = 4'b0000;
    localparam logic [3:0] SEL_SUB = 4'b0001;
    localparam logic [3:0] SEL_MUL = 4'b0010;
    localparam logic [3:0] SEL_DIV = 4'b0011;
    localparam logic [3:0] SEL_OR  = 4'b0100;
    localparam logic [3:0] SEL_AND = 4'b0101;
    localparam logic [3:0] SEL_SLT = 4'b0110;
    localparam logic [3:0] SEL_NOP = 4'b0111;

    logic [1:0]    state;
    logic [5:0]    ir_op;
    logic [4:0]    ir_rs;
    logic [4:0]    ir_rt;
    logic [4:0]    ir_rd;
    logic [5:0]    ir_fn;
    logic [DW-1:0] res_q;
    logic          z_q;
    logic [DW-1:0] rf [NREGS];
    logic [3:0]    dec;
    logic [DW-1:0] rs_v;
    logic [DW-1:0] rt_v;
    logic          is_nop;
    logic [4:0]    unused_shamt;
`ifdef ALU_DIV0_GUARD_EN
    logic          div0_q;
`endif

    assign unused_shamt = bus.in_instr[10:6];
    assign bus.in_ready = (state == IDLE);
    assign rs_v         = (ir_rs == 5'd0) ? '0 : rf[ir_rs];
    assign rt_v         = (ir_rt == 5'd0) ? '0 : rf[ir_rt];
    assign dbg_rdata    = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];
    // alu_sel stays at NOP from READ to WB for anything that must not retire
    assign is_nop       = (bus.alu_sel == SEL_NOP);

    always_comb begin
        dec = SEL_NOP;
        if (ir_op == 6'd0) begin
            unique case (ir_fn)
                6'h20:   dec = SEL_ADD;
                6'h22:   dec = SEL_SUB;
                6'h18:   dec = SEL_MUL;
                6'h1A:   dec = SEL_DIV;
                6'h25:   dec = SEL_OR;
                6'h24:   dec = SEL_AND;
                6'h2A:   dec = SEL_SLT;
                default: dec = SEL_NOP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ir_op       <= '0;
            ir_rs       <= '0;
            ir_rt       <= '0;
            ir_rd       <= '0;
            ir_fn       <= '0;
            res_q       <= '0;
            z_q         <= 1'b0;
            bus.alu_op1 <= '0;
            bus.alu_op2 <= '0;
            bus.alu_sel <= SEL_NOP;
            wb_valid    <= 1'b0;
            wb_we       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            zero_flag   <= 1'b0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
`ifdef ALU_DIV0_GUARD_EN
            div0_q      <= 1'b0;
            div0_err    <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
`ifdef ALU_DIV0_GUARD_EN
            div0_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // debug write lands at the accept edge, before READ
                    if (dbg_we && dbg_addr != 5'd0)
                        rf[dbg_addr] <= dbg_wdata;
                    if (bus.in_valid) begin
                        ir_op <= bus.in_instr[31:26];
                        ir_rs <= bus.in_instr[25:21];
                        ir_rt <= bus.in_instr[20:16];
                        ir_rd <= bus.in_instr[15:11];
                        ir_fn <= bus.in_instr[5:0];
                        state <= READ;
                    end
                end
                READ: begin
                    bus.alu_op1 <= rs_v;
                    bus.alu_op2 <= rt_v;
                    bus.alu_sel <= dec;
`ifdef ALU_DIV0_GUARD_EN
                    div0_q <= (dec == SEL_DIV) && (rt_v == '0);
                    if ((dec == SEL_DIV) && (rt_v == '0))
                        bus.alu_sel <= SEL_NOP;
`endif
                    state <= EXEC;
                end
                EXEC: begin
                    if (!is_nop) begin
                        res_q <= bus.alu_res;
                        z_q   <= bus.alu_z;
                    end
                    state <= WB;
                end
                default: begin
                    wb_valid <= 1'b1;
                    wb_addr  <= ir_rd;
                    wb_data  <= is_nop ? '0 : res_q;
                    if (!is_nop)
                        zero_flag <= z_q;
                    if (!is_nop && ir_rd != 5'd0) begin
                        wb_we     <= 1'b1;
                        rf[ir_rd] <= res_q;
                    end
`ifdef ALU_DIV0_GUARD_EN
                    div0_err <= div0_q;
`endif
                    bus.alu_sel <= SEL_NOP;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule
